// File: rtl/jtopl_snd_pkg.sv
// Shared constants for the OPL sound output path: default sample width,
// gain field width and the saturation limits for the default width.
package jtopl_snd_pkg;

   localparam int SND_SW = 13;
   localparam int GAIN_W = 2;

   // Largest positive and most negative two's-complement values at SND_SW bits
   localparam logic [SND_SW-1:0] SND_MAX = {1'b0, {(SND_SW-1){1'b1}}};
   localparam logic [SND_SW-1:0] SND_MIN = {1'b1, {(SND_SW-1){1'b0}}};

endpackage

// File: rtl/jtopl_snd_sat.sv
// Combinational gain stage: arithmetic left shift by 0..3 computed three bits
// wider than the sample, then clamped back into SW bits when it overflows.
module jtopl_snd_sat
   import jtopl_snd_pkg::*;
#(
   parameter int SW = SND_SW
) (
   input  logic [SW-1:0]     snd,
   input  logic [GAIN_W-1:0] gain,
   output logic [SW-1:0]     dout
);

   localparam int XW = SW + 3;
   localparam logic [SW-1:0] SAT_MAX = {1'b0, {(SW-1){1'b1}}};
   localparam logic [SW-1:0] SAT_MIN = {1'b1, {(SW-1){1'b0}}};

   logic signed [XW-1:0] ext;
   logic signed [XW-1:0] shifted;
   logic [3:0]           agree;

   // Sign-extend into the headroom bits so a shift of up to 3 never loses the sign
   assign ext     = {{3{snd[SW-1]}}, snd};
   assign shifted = ext <<< gain;

   // The result fits in SW bits only if every headroom bit repeats bit SW-1
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_agree
         assign agree[gi] = (shifted[SW-1+gi] == shifted[SW-1]);
      end
   endgenerate

   // Pass the shifted value, or clamp toward the input's sign on overflow
   always_comb begin
      dout = shifted[SW-1:0];
      if (!(&agree)) begin
         dout = snd[SW-1] ? SAT_MIN : SAT_MAX;
      end
   end

endmodule

// File: rtl/jtopl_snd_fifo.sv
// Captures one accumulator sample per frame, applies the gain stage and
// queues the result in a small FIFO drained over a valid/ready handshake.
// Overruns drop the new sample and raise a sticky flag.
module jtopl_snd_fifo
   import jtopl_snd_pkg::*;
#(
   parameter int SW    = SND_SW,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cenop,
   input  logic              zero,
   input  logic [SW-1:0]     snd,
   input  logic [GAIN_W-1:0] gain,
   output logic [SW-1:0]     dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [AW:0]       level,
   output logic              ovr,
   input  logic              ovr_clr
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

   logic            pend_reg;
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [AW:0]     level_reg;
   logic [SW-1:0]   dout_reg;
   logic            ovr_reg;
   logic [SW-1:0]   mem [0:DEPTH-1];

   logic [SW-1:0]   gained;
   logic            push;
   logic            pop;
   logic            full;
   logic            wr_en;
   logic            ovr_set;
   logic [AW-1:0]   rd_next_ptr;

   jtopl_snd_sat #(.SW(SW)) u_sat (
      .snd  (snd),
      .gain (gain),
      .dout (gained)
   );

   // Handshake decode: a push is accepted when there is room or a pop frees a slot
   always_comb begin
      push        = pend_reg;
      pop         = (level_reg != '0) && dout_ready;
      full        = (level_reg == FULL_LVL);
      wr_en       = push && (!full || pop);
      ovr_set     = push && full && !pop;
      rd_next_ptr = rd_ptr_reg + 1'b1;
   end

   // Control state: capture flag, pointers, occupancy, output register, overrun flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg   <= 1'b0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         dout_reg   <= '0;
         ovr_reg    <= 1'b0;
      end else begin
         // snd settles on the capture edge, so it is sampled one clock later
         pend_reg <= cenop & zero;

         if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)   rd_ptr_reg <= rd_next_ptr;

         case ({wr_en, pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: ;
         endcase

         // Keep dout equal to the head: load a push that becomes the new head,
         // otherwise follow the pointer to the next stored entry after a pop
         if (wr_en && ((level_reg == '0) || (pop && level_reg == LVL_ONE))) begin
            dout_reg <= gained;
         end else if (pop && level_reg > LVL_ONE) begin
            dout_reg <= mem[rd_next_ptr];
         end

         if (ovr_set) begin
            ovr_reg <= 1'b1;
         end else if (ovr_clr) begin
            ovr_reg <= 1'b0;
         end
      end
   end

   // Sample storage, written without reset so it maps onto plain RAM
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= gained;
   end

   assign dout       = dout_reg;
   assign dout_valid = (level_reg != '0);
   assign level      = level_reg;
   assign ovr        = ovr_reg;

endmodule

// File: tb/tb_jtopl_snd_fifo.sv
// Bench for jtopl_snd_fifo: gain table, overrun/full/reset sequences, and a
// randomized run compared against a queue-based reference model.
module tb_jtopl_snd_fifo;

   localparam int SW    = 13;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b0;
   logic          cenop      = 1'b0;
   logic          zero       = 1'b0;
   logic [SW-1:0] snd        = '0;
   logic [1:0]    gain       = '0;
   logic          dout_ready = 1'b0;
   logic          ovr_clr    = 1'b0;
   logic [SW-1:0] dout;
   logic          dout_valid;
   logic [AW:0]   level;
   logic          ovr;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [SW-1:0] snd;
      logic [1:0]    gain;
      logic [SW-1:0] exp;
   } vec_t;

   vec_t vecs [12];

   // reference model state
   logic [SW-1:0] q [$];
   logic          pend_m;
   logic          ovr_m;
   logic [SW-1:0] last_m;

   always #5 clk = ~clk;

   jtopl_snd_fifo #(.SW(SW), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cenop      (cenop),
      .zero       (zero),
      .snd        (snd),
      .gain       (gain),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .level      (level),
      .ovr        (ovr),
      .ovr_clr    (ovr_clr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // gain in plain integer arithmetic, clamped to the signed SW-bit range
   function automatic logic [SW-1:0] gain_ref(input logic [SW-1:0] s, input int g);
      int v;
      v = $signed(s);
      v = v * (1 << g);
      if (v > 4095)  v = 4095;
      if (v < -4096) v = -4096;
      return v[SW-1:0];
   endfunction

   // one frame: strobe on the capture edge, return one cycle after the push edge
   task automatic frame(input logic [SW-1:0] s, input logic [1:0] g);
      snd = s; gain = g; cenop = 1'b1; zero = 1'b1;
      tick();
      cenop = 1'b0; zero = 1'b0;
      tick();
   endtask

   task automatic drain_expect(input string name, input logic [SW-1:0] v);
      chk({name, "_valid"}, 32'(dout_valid), 32'd1);
      chk(name, 32'(dout), 32'(v));
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{13'h0123, 2'd0, 13'h0123};
      vecs[1]  = '{13'h0500, 2'd2, 13'h0FFF};
      vecs[2]  = '{13'h1F00, 2'd2, 13'h1C00};
      vecs[3]  = '{13'h1800, 2'd3, 13'h1000};
      vecs[4]  = '{13'h0FFF, 2'd0, 13'h0FFF};
      vecs[5]  = '{13'h1000, 2'd0, 13'h1000};
      vecs[6]  = '{13'h03FF, 2'd2, 13'h0FFC};
      vecs[7]  = '{13'h0400, 2'd3, 13'h0FFF};
      vecs[8]  = '{13'h0400, 2'd1, 13'h0800};
      vecs[9]  = '{13'h1FFF, 2'd3, 13'h1FF8};
      vecs[10] = '{13'h1400, 2'd1, 13'h1000};
      vecs[11] = '{13'h1C00, 2'd1, 13'h1800};

      // ---- reset held while strobing capture inputs ----
      rst_n = 1'b0;
      repeat (3) begin
         cenop = 1'b1; zero = 1'b1; snd = 13'h0AAA; dout_ready = 1'b1;
         tick();
         cenop = 1'b0; zero = 1'b0;
         tick();
      end
      dout_ready = 1'b0;
      chk("rst_valid", 32'(dout_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_ovr",   32'(ovr), 32'd0);
      chk("rst_dout",  32'(dout), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      tick();
      chk("post_rst_level", 32'(level), 32'd0);

      // ---- cenop or zero alone must not capture ----
      snd = 13'h0055;
      cenop = 1'b1; zero = 1'b0; tick();
      cenop = 1'b0; zero = 1'b1; tick();
      zero = 1'b0; tick(); tick();
      chk("no_capture_level", 32'(level), 32'd0);

      // ---- gain/saturation table with latency check ----
      for (int i = 0; i < 12; i++) begin
         snd = vecs[i].snd; gain = vecs[i].gain; cenop = 1'b1; zero = 1'b1;
         tick();
         cenop = 1'b0; zero = 1'b0;
         chk($sformatf("vec%0d_lat1_valid", i), 32'(dout_valid), 32'd0);
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'd1);
         chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp));
         chk($sformatf("vec%0d_level", i), 32'(level), 32'd1);
         dout_ready = 1'b1;
         tick();
         dout_ready = 1'b0;
         chk($sformatf("vec%0d_pop_level", i), 32'(level), 32'd0);
         chk($sformatf("vec%0d_hold_dout", i), 32'(dout), 32'(vecs[i].exp));
      end

      // ---- overrun: five frames into a four-entry FIFO ----
      for (int i = 1; i <= 5; i++) frame(13'(i), 2'd0);
      chk("ovr_level", 32'(level), 32'd4);
      chk("ovr_flag",  32'(ovr), 32'd1);
      for (int i = 1; i <= 4; i++) drain_expect($sformatf("ovr_drain%0d", i), 13'(i));
      chk("ovr_drained_level", 32'(level), 32'd0);
      chk("ovr_sticky", 32'(ovr), 32'd1);
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
      chk("ovr_cleared", 32'(ovr), 32'd0);

      // ---- full FIFO with a pop on the push cycle ----
      for (int i = 1; i <= 4; i++) frame(13'(i), 2'd0);
      chk("full_level", 32'(level), 32'd4);
      snd = 13'd9; cenop = 1'b1; zero = 1'b1;
      tick();
      cenop = 1'b0; zero = 1'b0; dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      chk("fullpop_level", 32'(level), 32'd4);
      chk("fullpop_ovr",   32'(ovr), 32'd0);
      drain_expect("fullpop_d0", 13'd2);
      drain_expect("fullpop_d1", 13'd3);
      drain_expect("fullpop_d2", 13'd4);
      drain_expect("fullpop_d3", 13'd9);
      chk("fullpop_empty", 32'(dout_valid), 32'd0);

      // ---- overrun and ovr_clr on the same edge: set wins ----
      for (int i = 1; i <= 4; i++) frame(13'(i), 2'd0);
      snd = 13'd7; cenop = 1'b1; zero = 1'b1;
      tick();
      cenop = 1'b0; zero = 1'b0; ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("setwins_ovr",   32'(ovr), 32'd1);
      chk("setwins_level", 32'(level), 32'd4);
      chk("setwins_head",  32'(dout), 32'd1);

      // ---- async reset between capture edge and push edge ----
      drain_expect("arst_pre_pop", 13'd1);
      snd = 13'h0321; cenop = 1'b1; zero = 1'b1;
      tick();
      cenop = 1'b0; zero = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(dout_valid), 32'd0);
      chk("arst_level", 32'(level), 32'd0);
      chk("arst_ovr",   32'(ovr), 32'd0);
      chk("arst_dout",  32'(dout), 32'd0);
      #1 rst_n = 1'b1;
      tick();
      tick();
      chk("arst_no_push_level", 32'(level), 32'd0);
      chk("arst_no_push_valid", 32'(dout_valid), 32'd0);

      // ---- randomized run against the queue model ----
      cenop = 1'b0; zero = 1'b0; dout_ready = 1'b0; ovr_clr = 1'b0;
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      q.delete();
      pend_m = 1'b0;
      ovr_m  = 1'b0;
      last_m = '0;
      for (int c = 0; c < 3000; c++) begin
         int  rdy_pct;
         logic ovf;
         rdy_pct = (c / 500) % 3 == 0 ? 15 : ((c / 500) % 3 == 1 ? 50 : 90);
         cenop      = 1'($urandom_range(0, 1));
         zero       = cenop ? 1'($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
         snd        = SW'($urandom);
         gain       = 2'($urandom_range(0, 3));
         dout_ready = 1'($urandom_range(0, 99) < rdy_pct);
         ovr_clr    = 1'($urandom_range(0, 31) == 0);

         // what the upcoming edge must do
         ovf = 1'b0;
         if (q.size() != 0 && dout_ready) void'(q.pop_front());
         if (pend_m) begin
            if (q.size() < DEPTH) q.push_back(gain_ref(snd, int'(gain)));
            else ovf = 1'b1;
         end
         if (ovf) ovr_m = 1'b1;
         else if (ovr_clr) ovr_m = 1'b0;
         pend_m = cenop & zero;
         if (q.size() != 0) last_m = q[0];

         tick();
         chk("rnd_level", 32'(level), 32'(q.size()));
         chk("rnd_valid", 32'(dout_valid), 32'(q.size() != 0));
         chk("rnd_dout",  32'(dout), 32'(last_m));
         chk("rnd_ovr",   32'(ovr), 32'(ovr_m));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
